csr_timer: RTL and testbench
============================

# csr_timer

Consumer of the 64-bit stable counter. Serves `rdcnt` reads: rdcntvl.w, rdcntvh.w and rdcntid.w. Owns the LoongArch timer CSRs TID, TCFG, TVAL and TICLR, and drives the timer interrupt line (ESTAT.IS[11]). Sits between the stable counter and the execute-stage/CSR unit.

## Interface
Parameters:
- `TIMER_W`, 32, width of TCFG/TVAL (n); legal range 8..32.
- `TID_RESET`, 32'h0, reset value of TID.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stable_cnt`  in  64  live value from the stable counter.
- `csr_we`  in  1  CSR write strobe.
- `csr_waddr`  in  14  CSR write address.
- `csr_wdata`  in  32  CSR write data.
- `csr_raddr`  in  14  CSR read address.
- `csr_rdata`  out  32  combinational CSR read data.
- `rdcnt_valid`  in  1  rdcnt request.
- `rdcnt_op`  in  2  request type: 00 VL, 01 VH, 10 ID, 11 reserved.
- `rdcnt_ready`  out  1  request accepted when high with valid.
- `rdcnt_rvalid`  out  1  result valid.
- `rdcnt_rdata`  out  32  result.
- `rdcnt_rready`  in  1  result consumed.
- `timer_irq`  out  1  TI, level, to ESTAT.IS[11].

## Operation
- CSR addresses: TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- TCFG fields: bit0 En, bit1 Periodic, [TIMER_W-1:2] InitVal.
- CSR reads:
  - TCFG and TVAL bits ≥ TIMER_W read 0.
  - TICLR reads 0.
  - Unmapped addresses read 0.
- Write TID: full 32-bit load.
- Write TCFG:
  - Store the fields.
  - Load TVAL = {InitVal, 2'b00} on the next edge.
- Write TVAL: ignored (read-only).
- Write TICLR with wdata[0]=1: clears TI. Other bits are ignored.
- Countdown, each cycle with En=1 and TVAL≠0:
  - TVAL ≠ 1: TVAL ← TVAL−1.
  - TVAL = 1: TI ← 1. TVAL ← Periodic ? {InitVal,2'b00} : 0.
- Idle/stop conditions:
  - En=0: TVAL holds.
  - TVAL=0 holds, with no further interrupt. This covers one-shot after expiry and InitVal=0.
- Priorities:
  - TCFG write beats countdown in the same cycle. TVAL is loaded and there is no expiry that cycle.
  - An expiry set beats a same-cycle TICLR clear; TI stays 1.
- rdcnt path is a single output buffer:
  - rdcnt_ready = !rdcnt_rvalid || rdcnt_rready.
  - On accept, capture the result from stable_cnt sampled in the accept cycle:
    - VL → stable_cnt[31:0]
    - VH → stable_cnt[63:32]
    - ID → TID, including a same-cycle TID write's old value
    - op 11 → 0
  - rdcnt_rvalid and rdcnt_rdata stay stable until rdcnt_rready.
- VL/VH pairs are not atomic; software reads VH, VL, VH.

## Timing
- Reset (async assert, sync release): TID=TID_RESET; TCFG=0, TVAL=0, timer_irq=0, rdcnt_rvalid=0, rdcnt_rdata=0.
- csr_rdata: zero-cycle combinational from current state. A write is visible the cycle after csr_we.
- TCFG write in cycle t: TVAL={InitVal,00} at t+1, first decrement at t+2.
- With TVAL=N at cycle t and En=1, timer_irq rises at t+N.
- The periodic period is {InitVal,00} cycles.
- rdcnt latency is 1 cycle (accept at t, rvalid at t+1). Throughput is 1/cycle with rdcnt_rready tied high.
- Reset mid-transfer drops the pending result. No stale rvalid after release.

## Structure
- Package `csr_timer_pkg` holds:
  - CSR address constants (CSR_TID, CSR_TCFG, CSR_TVAL, CSR_TICLR)
  - rdcnt_op encodings (RDCNT_VL, RDCNT_VH, RDCNT_ID)
  - TCFG bit positions (TCFG_EN, TCFG_PERIODIC)
- Sub-module `timer_core`: TCFG/TVAL/TI registers, countdown, TICLR.
- The top module holds TID, CSR read mux, and the rdcnt output buffer.

## Test plan
- Reset, then write TCFG=0x0000_0011 (En, one-shot, InitVal=4): TVAL=0x10 next cycle; timer_irq rises 16 cycles later; TVAL stays 0 and there is no second irq in 100 cycles.
- TCFG=0x0000_000B (En, Periodic, InitVal=2): TVAL reloads to 8 and irq fires every 8 cycles. TICLR write 1 clears TI. A TICLR on the expiry cycle leaves timer_irq=1.
- stable_cnt=0x1234_5678_9ABC_DEF0: VL then VH, rready=1 → rdata 0x9ABC_DEF0 then 0x1234_5678, each 1 cycle after accept.
- rdcnt_rready=0 for 3 cycles after a result: rdcnt_ready=0, rdata held. A new request is accepted the cycle rready rises.
- Write TID=0xCAFE_0001 with an ID request in the same cycle → rdata=TID_RESET. The next ID request → 0xCAFE_0001. op 11 → 0.
- rst_n pulsed low mid-countdown with rvalid=1 → all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/csr_timer_pkg.sv
// Shared constants for the timer CSR block: CSR addresses, rdcnt request
// encodings and TCFG bit positions.
package csr_timer_pkg;

    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    localparam logic [1:0] RDCNT_VL = 2'b00;
    localparam logic [1:0] RDCNT_VH = 2'b01;
    localparam logic [1:0] RDCNT_ID = 2'b10;

    localparam int unsigned TCFG_EN       = 0;
    localparam int unsigned TCFG_PERIODIC = 1;

endpackage

// File: rtl/csr_timer_core.sv
// Timer registers: TCFG, the TVAL down-counter and the TI flag.
// A TCFG write reloads TVAL and suppresses that cycle's countdown; an
// expiry outranks a same-cycle TICLR clear.
module csr_timer_core
    import csr_timer_pkg::*;
#(
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    input  logic               ticlr_clr,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               ti
);

    logic               en;
    logic               periodic;
    logic [TIMER_W-1:0] reload;
    logic               expire;

    // Decode the live configuration and flag the terminal-count cycle.
    always_comb begin
        en       = tcfg[TCFG_EN];
        periodic = tcfg[TCFG_PERIODIC];
        reload   = {tcfg[TIMER_W-1:2], 2'b00};
        expire   = !tcfg_we && en && (tval == TIMER_W'(1));
    end

    // TCFG storage and TVAL countdown / reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcfg <= '0;
            tval <= '0;
        end else if (tcfg_we) begin
            tcfg <= tcfg_wdata;
            tval <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
        end else if (en && (tval != '0)) begin
            if (tval == TIMER_W'(1)) begin
                tval <= periodic ? reload : '0;
            end else begin
                tval <= tval - TIMER_W'(1);
            end
        end
    end

    // Timer interrupt flag: set on expiry, cleared by TICLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ti <= 1'b0;
        end else if (expire) begin
            ti <= 1'b1;
        end else if (ticlr_clr) begin
            ti <= 1'b0;
        end
    end

endmodule

// File: rtl/csr_timer.sv
// Timer CSR block: TID register, CSR read mux, the rdcnt single-entry
// result buffer, and the timer core producing the TI interrupt level.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter int unsigned TIMER_W   = 32,
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] stable_cnt,
    input  logic        csr_we,
    input  logic [13:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [13:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic        rdcnt_valid,
    input  logic [1:0]  rdcnt_op,
    output logic        rdcnt_ready,
    output logic        rdcnt_rvalid,
    output logic [31:0] rdcnt_rdata,
    input  logic        rdcnt_rready,
    output logic        timer_irq
);

    logic [31:0]        tid;
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] tval;
    logic               tid_we;
    logic               tcfg_we;
    logic               ticlr_clr;
    logic               rdcnt_accept;
    logic [31:0]        rdcnt_result;

    // Write decode; TVAL writes are deliberately dropped.
    always_comb begin
        tid_we    = csr_we && (csr_waddr == CSR_TID);
        tcfg_we   = csr_we && (csr_waddr == CSR_TCFG);
        ticlr_clr = csr_we && (csr_waddr == CSR_TICLR) && csr_wdata[0];
    end

    csr_timer_core #(
        .TIMER_W (TIMER_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .tcfg_we    (tcfg_we),
        .tcfg_wdata (csr_wdata[TIMER_W-1:0]),
        .ticlr_clr  (ticlr_clr),
        .tcfg       (tcfg),
        .tval       (tval),
        .ti         (timer_irq)
    );

    // TID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid <= TID_RESET;
        end else if (tid_we) begin
            tid <= csr_wdata;
        end
    end

    // Combinational CSR read mux; narrow timer fields are zero-extended.
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_TID:  csr_rdata = tid;
            CSR_TCFG: csr_rdata[TIMER_W-1:0] = tcfg;
            CSR_TVAL: csr_rdata[TIMER_W-1:0] = tval;
            default:  csr_rdata = '0;
        endcase
    end

    // rdcnt handshake and result select from state sampled in the accept cycle.
    always_comb begin
        rdcnt_ready  = !rdcnt_rvalid || rdcnt_rready;
        rdcnt_accept = rdcnt_valid && rdcnt_ready;
        case (rdcnt_op)
            RDCNT_VL: rdcnt_result = stable_cnt[31:0];
            RDCNT_VH: rdcnt_result = stable_cnt[63:32];
            RDCNT_ID: rdcnt_result = tid;
            default:  rdcnt_result = '0;
        endcase
    end

    // Single-entry result buffer; contents hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdcnt_rvalid <= 1'b0;
            rdcnt_rdata  <= '0;
        end else if (rdcnt_accept) begin
            rdcnt_rvalid <= 1'b1;
            rdcnt_rdata  <= rdcnt_result;
        end else if (rdcnt_rready) begin
            rdcnt_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: timer one-shot/periodic behaviour, TICLR
// priority, rdcnt buffering/backpressure, TID forwarding and async reset.
module tb_csr_timer;
    import csr_timer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] stable_cnt;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        rdcnt_valid;
    logic [1:0]  rdcnt_op;
    logic        rdcnt_ready;
    logic        rdcnt_rvalid;
    logic [31:0] rdcnt_rdata;
    logic        rdcnt_rready;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;
    int n;
    int bad;

    csr_timer #(
        .TIMER_W   (32),
        .TID_RESET (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stable_cnt   (stable_cnt),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .rdcnt_valid  (rdcnt_valid),
        .rdcnt_op     (rdcnt_op),
        .rdcnt_ready  (rdcnt_ready),
        .rdcnt_rvalid (rdcnt_rvalid),
        .rdcnt_rdata  (rdcnt_rdata),
        .rdcnt_rready (rdcnt_rready),
        .timer_irq    (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [13:0] addr, input string tag, input logic [31:0] exp);
        csr_raddr = addr;
        #1;
        chk(tag, 64'(csr_rdata), 64'(exp));
    endtask

    task automatic wr(input logic [13:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_waddr = addr;
        csr_wdata = data;
        step();
        csr_we    = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        stable_cnt   = 64'h0;
        csr_we       = 1'b0;
        csr_waddr    = '0;
        csr_wdata    = '0;
        csr_raddr    = '0;
        rdcnt_valid  = 1'b0;
        rdcnt_op     = 2'b00;
        rdcnt_rready = 1'b1;
        step();
        step();
        chk("rst_irq", 64'(timer_irq), 64'h0);
        chk("rst_rvalid", 64'(rdcnt_rvalid), 64'h0);
        chk("rst_rdata", 64'(rdcnt_rdata), 64'h0);
        rd(CSR_TID, "rst_tid", 32'h0);
        rd(CSR_TCFG, "rst_tcfg", 32'h0);
        rd(CSR_TVAL, "rst_tval", 32'h0);
        rst_n = 1'b1;
        step();

        // One-shot, InitVal=4 -> TVAL=16, irq 16 cycles later
        wr(CSR_TCFG, 32'h0000_0011);
        rd(CSR_TVAL, "oneshot_load", 32'h10);
        rd(CSR_TCFG, "tcfg_read", 32'h11);
        n = 0;
        while (!timer_irq && n < 40) begin
            step();
            n++;
        end
        chk("oneshot_latency", 64'(n), 64'd16);
        rd(CSR_TVAL, "oneshot_tval0", 32'h0);
        wr(CSR_TICLR, 32'h0000_0001);
        chk("ticlr_clear", 64'(timer_irq), 64'h0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (timer_irq || dut.csr_rdata != 32'h0) bad++;
        end
        chk("oneshot_no_rearm", 64'(bad), 64'h0);
        rd(CSR_TICLR, "ticlr_reads0", 32'h0);
        rd(14'h055, "unmapped_reads0", 32'h0);

        // Periodic, InitVal=2 -> reload 8
        wr(CSR_TCFG, 32'h0000_000B);
        rd(CSR_TVAL, "periodic_load", 32'h8);
        n = 0;
        while (!timer_irq && n < 40) begin
            step();
            n++;
        end
        chk("periodic_first", 64'(n), 64'd8);
        rd(CSR_TVAL, "periodic_reload", 32'h8);
        wr(CSR_TICLR, 32'h0000_0001);
        chk("periodic_clear", 64'(timer_irq), 64'h0);
        n = 1;
        while (!timer_irq && n < 40) begin
            step();
            n++;
        end
        chk("periodic_period", 64'(n), 64'd8);
        wr(CSR_TICLR, 32'h0000_0001);
        chk("periodic_clear2", 64'(timer_irq), 64'h0);
        repeat (6) step();
        rd(CSR_TVAL, "pre_expiry_tval", 32'h1);
        chk("pre_expiry_irq", 64'(timer_irq), 64'h0);
        wr(CSR_TICLR, 32'h0000_0001);
        chk("expiry_beats_clear", 64'(timer_irq), 64'h1);
        rd(CSR_TVAL, "expiry_reload", 32'h8);
        wr(CSR_TVAL, 32'h0000_FFFF);
        rd(CSR_TVAL, "tval_write_ignored", 32'h7);
        wr(CSR_TICLR, 32'h0000_0001);
        repeat (5) step();
        rd(CSR_TVAL, "tcfg_race_tval1", 32'h1);
        wr(CSR_TCFG, 32'h0000_0005);
        rd(CSR_TVAL, "tcfg_beats_count", 32'h4);
        chk("tcfg_race_no_irq", 64'(timer_irq), 64'h0);
        wr(CSR_TCFG, 32'h0000_0010);
        repeat (5) step();
        rd(CSR_TVAL, "disabled_holds", 32'h10);

        // rdcnt VL / VH back-to-back
        stable_cnt   = 64'h1234_5678_9ABC_DEF0;
        rdcnt_rready = 1'b1;
        rdcnt_valid  = 1'b1;
        rdcnt_op     = RDCNT_VL;
        #1;
        chk("rdcnt_ready_idle", 64'(rdcnt_ready), 64'h1);
        step();
        chk("vl_rvalid", 64'(rdcnt_rvalid), 64'h1);
        chk("vl_rdata", 64'(rdcnt_rdata), 64'h9ABC_DEF0);
        rdcnt_op = RDCNT_VH;
        step();
        chk("vh_rdata", 64'(rdcnt_rdata), 64'h1234_5678);

        // Backpressure: hold result 3 cycles
        rdcnt_rready = 1'b0;
        rdcnt_op     = RDCNT_VL;
        stable_cnt   = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        chk("bp_ready_low", 64'(rdcnt_ready), 64'h0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rdcnt_ready !== 1'b0 || rdcnt_rvalid !== 1'b1 || rdcnt_rdata !== 32'h1234_5678) bad++;
        end
        chk("bp_hold", 64'(bad), 64'h0);
        rdcnt_rready = 1'b1;
        #1;
        chk("bp_ready_rises", 64'(rdcnt_ready), 64'h1);
        step();
        chk("bp_new_result", 64'(rdcnt_rdata), 64'hCCCC_DDDD);
        rdcnt_valid = 1'b0;
        step();
        chk("drain_rvalid", 64'(rdcnt_rvalid), 64'h0);

        // TID write with same-cycle ID read
        rdcnt_valid = 1'b1;
        rdcnt_op    = RDCNT_ID;
        wr(CSR_TID, 32'hCAFE_0001);
        chk("id_old_value", 64'(rdcnt_rdata), 64'h0);
        rd(CSR_TID, "tid_written", 32'hCAFE_0001);
        step();
        chk("id_new_value", 64'(rdcnt_rdata), 64'hCAFE_0001);
        rdcnt_op = 2'b11;
        step();
        chk("op_reserved", 64'(rdcnt_rdata), 64'h0);
        rdcnt_valid = 1'b0;
        step();

        // Async reset mid-countdown with a pending result
        wr(CSR_TCFG, 32'h0000_0011);
        wr(CSR_TICLR, 32'h0000_0000);
        rdcnt_valid  = 1'b1;
        rdcnt_op     = RDCNT_VL;
        rdcnt_rready = 1'b0;
        step();
        rdcnt_valid = 1'b0;
        chk("pre_reset_rvalid", 64'(rdcnt_rvalid), 64'h1);
        #1;
        rst_n     = 1'b0;
        csr_raddr = CSR_TVAL;
        #1;
        chk("async_rvalid", 64'(rdcnt_rvalid), 64'h0);
        chk("async_rdata", 64'(rdcnt_rdata), 64'h0);
        chk("async_tval", 64'(csr_rdata), 64'h0);
        chk("async_irq", 64'(timer_irq), 64'h0);
        rd(CSR_TID, "async_tid", 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_rvalid", 64'(rdcnt_rvalid), 64'h0);
        rd(CSR_TCFG, "post_reset_tcfg", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
